// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states and
// the fixed instruction/PC constants used by the fetch unit and IF/ID register.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a word
// arriving while the downstream stage is held. Priority: reset > flush > hold.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        skid_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr <= NOP;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      skid_instr <= NOP;
      skid_pc4   <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP;
      ifid_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (hold) begin
      if (load) begin
        skid_instr <= in_instr;
        skid_pc4   <= in_pc4;
        skid_valid <= 1'b1;
      end
    end else if (skid_valid) begin
      ifid_instr <= skid_instr;
      ifid_pc4   <= skid_pc4;
      ifid_valid <= 1'b1;
      skid_valid <= 1'b0;
    end else if (load) begin
      ifid_instr <= in_instr;
      ifid_pc4   <= in_pc4;
      ifid_valid <= 1'b1;
    end else begin
      // Nothing fetched and nothing held: the consumed slot becomes a bubble.
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register and FETCH/DRAIN/HELD request FSM around ifid_reg.
// Optional feature macro: PC_ALIGN_CHECK_EN (branch-target alignment fault).
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic        branch_taken,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        align_fault
`endif
);

  fetch_state_e state, next_state;
  logic [31:0]  pc_next;
  logic [31:0]  drain_addr, drain_next;
  logic [31:0]  target_eff;
  logic         br;
  logic         load;

  assign br = branch_taken & ~stall;

`ifdef PC_ALIGN_CHECK_EN
  assign target_eff = {branch_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset)
      align_fault <= 1'b0;
    else if (br && (branch_target[1:0] != 2'b00))
      align_fault <= 1'b1;
  end
`else
  assign target_eff = branch_target;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
    end else begin
      state      <= next_state;
      pc         <= pc_next;
      drain_addr <= drain_next;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    drain_next = drain_addr;
    imem_req   = 1'b1;
    imem_addr  = pc;
    load       = 1'b0;
    unique case (state)
      FETCH: begin
        load = imem_ack & ~br;
        if (br) begin
          pc_next = target_eff;
          if (!imem_ack) begin
            // The request already on the bus must complete at its old address.
            next_state = DRAIN;
            drain_next = pc;
          end
        end else if (imem_ack) begin
          pc_next = pc_plus4;
          if (stall) next_state = HELD;
        end
      end
      DRAIN: begin
        imem_addr = drain_addr;
        if (br) pc_next = target_eff;
        if (imem_ack) next_state = FETCH;
      end
      HELD: begin
        imem_req = 1'b0;
        if (br) begin
          pc_next    = target_eff;
          next_state = FETCH;
        end else if (!stall) begin
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (br),
    .hold       (stall),
    .load       (load),
    .in_instr   (imem_rdata),
    .in_pc4     (pc_plus4),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then random traffic,
// all compared against a queue-based behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef PC_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  always #5 clk = ~clk;

  // External PC+4 adder.
  assign pc_plus4 = pc + 32'd4;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .align_fault   (align_fault)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] m_pc;
  ifid_t       m_ifid;
  ifid_t       m_skid[$];
  logic        m_drain;
  logic [31:0] m_daddr;
  logic        m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic        br;
    logic        fetching;
    logic [31:0] tgt;
    ifid_t       e;
    if (reset) begin
      m_pc    = RST_PC;
      m_skid.delete();
      m_drain = 1'b0;
      m_daddr = '0;
      m_ifid  = '0;
      m_fault = 1'b0;
    end else begin
      br       = branch_taken & ~stall;
      fetching = (m_skid.size() == 0) && !m_drain;
      tgt      = branch_target;
`ifdef PC_ALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
      if (br && branch_target[1:0] != 2'b00) m_fault = 1'b1;
`endif
      if (br) begin
        m_ifid.valid = 1'b0;
        m_ifid.instr = 32'h0;
        m_skid.delete();
        if (m_drain) begin
          if (imem_ack) m_drain = 1'b0;
        end else if (fetching && !imem_ack) begin
          m_drain = 1'b1;
          m_daddr = m_pc;
        end
        m_pc = tgt;
      end else if (m_drain) begin
        if (imem_ack) m_drain = 1'b0;
      end else if (!fetching) begin
        if (!stall) begin
          m_ifid       = m_skid.pop_front();
          m_ifid.valid = 1'b1;
        end
      end else if (imem_ack) begin
        e.instr = imem_rdata;
        e.pc4   = m_pc + 32'd4;
        e.valid = 1'b1;
        if (stall) m_skid.push_back(e);
        else       m_ifid = e;
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_ifid.valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic exp_req;
    exp_req = (m_skid.size() == 0);
    check("pc", pc, m_pc);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_drain ? m_daddr : m_pc);
    check("ifid_instr", ifid_instr, m_ifid.instr);
    check("ifid_pc4", ifid_pc4, m_ifid.pc4);
    check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_ifid.valid});
`ifdef PC_ALIGN_CHECK_EN
    check("align_fault", {31'b0, align_fault}, {31'b0, m_fault});
`endif
  endtask

  task automatic step(input logic r, input logic t, input logic [31:0] tgt,
                      input logic s, input logic a, input logic [31:0] d);
    reset         = r;
    branch_taken  = t;
    branch_target = tgt;
    stall         = s;
    imem_ack      = a;
    imem_rdata    = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_pc = '0; m_ifid = '0; m_drain = 1'b0; m_daddr = '0; m_fault = 1'b0;

    // Reset, then zero-wait streaming.
    step(1, 0, 32'h0, 0, 0, 32'h0);
    check("rst_pc", pc, 32'h0040_0000);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h1);
    step(0, 0, 32'h0, 0, 1, 32'hA000_0001);
    check("stream_pc1", pc, 32'h0040_0004);
    check("stream_valid", {31'b0, ifid_valid}, 32'h1);
    step(0, 0, 32'h0, 0, 1, 32'hA000_0002);
    check("stream_pc2", pc, 32'h0040_0008);
    check("stream_pc4", ifid_pc4, 32'h0040_0008);

    // Ack on the second cycle of a 3-cycle stall goes to the skid buffer.
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 1, 1, 32'hB0B0_B0B0);
    check("held_req", {31'b0, imem_req}, 32'h0);
    check("held_ifid", ifid_instr, 32'hA000_0002);
    step(0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 32'h0);
    check("skid_instr", ifid_instr, 32'hB0B0_B0B0);
    check("skid_pc", pc, 32'h0040_000C);

    // Redirect with an outstanding request drains the old one.
    step(0, 1, 32'h0040_0100, 0, 0, 32'h0);
    check("drain_valid", {31'b0, ifid_valid}, 32'h0);
    check("drain_addr", imem_addr, 32'h0040_000C);
    step(0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    check("redir_addr", imem_addr, 32'h0040_0100);
    check("dropped_valid", {31'b0, ifid_valid}, 32'h0);

    // branch_taken ignored while stalled.
    step(0, 0, 32'h0, 0, 1, 32'hC000_0001);
    step(0, 1, 32'h1234_5678, 1, 0, 32'h0);
    check("stall_br_pc", pc, 32'h0040_0104);
    check("stall_br_ifid", ifid_instr, 32'hC000_0001);

    // PC wrap.
    step(0, 1, 32'hFFFF_FFFC, 0, 1, 32'h0);
    step(0, 0, 32'h0, 0, 1, 32'hC000_0002);
    check("wrap_pc", pc, 32'h0000_0000);

`ifdef PC_ALIGN_CHECK_EN
    step(0, 1, 32'h0040_0102, 0, 1, 32'h0);
    check("align_pc", pc, 32'h0040_0100);
    check("align_fault_set", {31'b0, align_fault}, 32'h1);
    step(0, 0, 32'h0, 0, 1, 32'h1);
    step(0, 1, 32'h0040_0200, 0, 1, 32'h0);
    check("align_sticky", {31'b0, align_fault}, 32'h1);
    step(1, 0, 32'h0, 0, 0, 32'h0);
    check("align_clear", {31'b0, align_fault}, 32'h0);
`endif

    // Random traffic, including resets with a late ack.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port pc, output, 32: current fetch PC, fed to the PC+4 adder.
REQ-005 SHALL have port pc_plus4, input, 32: adder result for pc.
REQ-006 SHALL have port branch_target, input, 32: redirect target from the ID-stage target adder.
REQ-007 SHALL have port branch_taken, input, 1: redirect request from ID.
REQ-008 SHALL have port stall, input, 1: hazard-unit hold of the IF/ID register.
REQ-009 SHALL have port imem_req, output, 1: instruction-memory request valid.
REQ-010 SHALL have port imem_addr, output, 32: request address.
REQ-011 SHALL have port imem_ack, input, 1: memory response valid; imem_rdata is meaningful only when it is high.
REQ-012 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-013 SHALL have ports ifid_instr, ifid_pc4 (output, 32 each) and ifid_valid (output, 1): the IF/ID pipeline register.

Function
REQ-014 SHALL implement states FETCH, DRAIN and HELD.
REQ-015 SHALL gate the redirect as br = branch_taken & ~stall; branch_taken SHALL be ignored while stall=1.
REQ-016 Event priority SHALL be reset > br > stall > imem_ack.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
- Once a request is issued, the address SHALL stay stable until imem_ack.
REQ-018 FETCH, imem_ack=1, stall=0, br=0: IF/ID SHALL load {imem_rdata, pc_plus4, valid=1}; pc SHALL load pc_plus4; state stays FETCH.
- Result: one instruction per cycle at zero-wait memory.
REQ-019 FETCH, imem_ack=1, stall=1: the word and pc_plus4 SHALL be captured into a one-entry skid buffer; pc SHALL advance to pc_plus4; next state HELD; IF/ID holds.
REQ-020 In HELD, imem_req SHALL be 0.
- stall falling to 0 with br=0: skid contents move to IF/ID with valid=1; next state FETCH.
REQ-021 br=1 in any state:
- pc SHALL load branch_target.
- ifid_valid SHALL clear and ifid_instr SHALL go to 32'h0 (NOP).
- Skid contents SHALL be discarded.
REQ-022 br=1 in FETCH with imem_ack=0 (request outstanding): next state DRAIN.
- br=1 in FETCH with imem_ack=1: the acked word is discarded; next state FETCH.
- br=1 in HELD: next state FETCH.
REQ-023 In DRAIN, imem_req SHALL stay 1 with the old address until imem_ack; that response SHALL be discarded; next state FETCH at the new pc.
- A further br during DRAIN SHALL update pc only.
REQ-024 stall=1 with imem_ack=0: IF/ID and pc SHALL hold; the request stays outstanding.
REQ-025 All address arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.

Reset
REQ-026 On reset the block SHALL set:
- pc = RESET_PC; state = FETCH; skid empty.
- ifid_instr = 32'h0, ifid_pc4 = 32'h0, ifid_valid = 0.
- imem_req = 1 on the first post-reset cycle.
REQ-027 Reset mid-request SHALL abandon the outstanding request without DRAIN; a late imem_ack after reset SHALL be treated as the ack for RESET_PC.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined:
- Adds output align_fault (1 bit), sticky until reset, set when br=1 and branch_target[1:0]!=0.
- pc loads branch_target with bits [1:0] cleared.
REQ-029 Macro PC_ALIGN_CHECK_EN undefined: the port is absent and branch_target is loaded unmodified.

Structure
REQ-030 Shared package mips_pkg SHALL hold:
- the fetch-state enum;
- the NOP constant 32'h0;
- the default reset-PC constant.
REQ-031 The IF/ID register plus skid buffer SHALL be one sub-module, ifid_reg.
- It takes load, flush and hold controls; the FSM and PC register stay in pc_fetch_unit.

Verification
REQ-032 Reset with RESET_PC=32'h0040_0000, imem_ack tied 1 -> pc steps 0x400000, 0x400004, 0x400008; ifid_pc4 lags one cycle; ifid_valid=1 from the second cycle.
REQ-033 ack on the second cycle of stall=1 held for 3 cycles -> HELD entered, imem_req=0, IF/ID unchanged; on stall release the skid word appears with ifid_valid=1 and pc = prior pc+4.
REQ-034 br=1, branch_target=32'h0040_0100, request outstanding (imem_ack=0) -> DRAIN; the next ack's data is dropped; next imem_addr=0x400100; ifid_valid=0 the cycle after br.
REQ-035 branch_taken=1 with stall=1 -> no redirect; pc and IF/ID unchanged.
REQ-036 pc=32'hFFFF_FFFC, ack -> pc wraps to 32'h0.
REQ-037 With PC_ALIGN_CHECK_EN defined, br with target 32'h0040_0102 -> pc=0x400100 and align_fault stays 1 until reset.
